// File: rtl/piso_serializer.sv
// piso_serializer: accepts a parallel word over valid/ready and shifts it out
// one bit per enabled clock, with stall support and gapless back-to-back words.
module piso_serializer #(
    parameter int DATA_WIDTH = 4,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_d,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_shift_en,
    output logic                  o_sd,
    output logic                  o_sd_valid,
    output logic                  o_last,
    output logic                  o_busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  at_last;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        at_last  = (state == SHIFT) && (cnt == LAST);
        o_ready  = (state == IDLE) || (at_last && i_shift_en);
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        // A load on the final bit's edge takes priority, giving gapless words
        if (o_ready && i_valid) begin
            state_nx = SHIFT;
            shreg_nx = i_d;
            cnt_nx   = '0;
        end else if (state == SHIFT && i_shift_en) begin
            state_nx = at_last ? IDLE : SHIFT;
            shreg_nx = at_last ? '0 :
                       LSB_FIRST ? {1'b0, shreg[DATA_WIDTH-1:1]} : {shreg[DATA_WIDTH-2:0], 1'b0};
            cnt_nx   = at_last ? '0 : cnt + CW'(1);
        end
    end

    assign o_sd_valid = (state == SHIFT);
    assign o_sd       = o_sd_valid && (LSB_FIRST ? shreg[0] : shreg[DATA_WIDTH-1]);
    assign o_last     = at_last;
    assign o_busy     = o_sd_valid;
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream stage of the 4-bit parallel-in/parallel-out register.
- Takes the registered parallel word (o_q of the PIPO stage) through a valid/ready handshake and shifts it out one bit per enabled clock.
- Exposes serial data, a valid flag and a last-bit marker to the next serial consumer.
- Supports a downstream stall input and back-to-back words with no idle cycle.

Parameters:
- DATA_WIDTH, 4, word width in bits; legal range 2 to 32.
- LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_d  input  DATA_WIDTH  parallel word from the upstream PIPO register.
- i_valid  input  1  i_d holds a word to transfer.
- o_ready  output  1  block accepts i_d on this edge; combinational.
- i_shift_en  input  1  downstream permits advance by one bit this cycle.
- o_sd  output  1  current serial bit; registered.
- o_sd_valid  output  1  o_sd is a valid data bit; registered.
- o_last  output  1  o_sd is the final bit of the current word.
- o_busy  output  1  a word is in flight; equal to o_sd_valid.

Behaviour:
- Reset (i_rst low, asynchronous, dominant over all inputs):
  - state = IDLE; shift register = 0; bit counter = 0.
  - o_sd = 0, o_sd_valid = 0, o_last = 0, o_busy = 0, o_ready = 1.
  - Release is taken on the next rising edge. A word in flight is discarded with no partial output after release.
- States: IDLE, SHIFT. Bit counter width is $clog2(DATA_WIDTH) and counts 0 to DATA_WIDTH-1.
- o_ready = (state==IDLE) OR (state==SHIFT AND cnt==DATA_WIDTH-1 AND i_shift_en).
- IDLE:
  - If i_valid is high on the edge, load shreg <= i_d, cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - o_sd = shreg[DATA_WIDTH-1] when LSB_FIRST=0, shreg[0] when LSB_FIRST=1.
  - o_sd_valid = 1; o_last = (cnt==DATA_WIDTH-1).
- SHIFT, edge with i_shift_en=0: all state held. o_sd, o_sd_valid and o_last are unchanged (stall).
- SHIFT, edge with i_shift_en=1 and cnt < DATA_WIDTH-1:
  - Shift toward the output end; fill the vacated bit with 0.
  - cnt <= cnt+1.
- SHIFT, edge with i_shift_en=1 and cnt == DATA_WIDTH-1:
  - If i_valid is high, load the new word, cnt <= 0, stay in SHIFT. There is no gap between words.
  - Otherwise go to IDLE and clear the shift register.
- Latency: a word accepted at edge k shows its first bit on o_sd after edge k. It completes after DATA_WIDTH enabled edges. Throughput is DATA_WIDTH cycles per word.
- i_valid while o_ready=0: ignored. The upstream source holds i_d and i_valid until a handshake occurs.
- i_d is sampled only on the accepting edge. Later changes to i_d do not affect the word in flight.
- In IDLE: i_shift_en has no effect and o_last = 0.

Test Plan:
1. Reset, then release; i_d=4'b1011, i_valid=1 for one cycle, i_shift_en=1 throughout.
   -> o_ready=1 before accept.
   -> o_sd sequence 1,0,1,1 on consecutive cycles, o_sd_valid=1 for exactly 4 cycles, o_last=1 only on the 4th.
   -> Then IDLE with o_sd_valid=0.
2. Back-to-back: i_valid held high, 4'b1011 then 4'b0110.
   -> o_sd = 1,0,1,1,0,1,1,0 with o_sd_valid continuously 1 for 8 cycles.
   -> o_ready pulses high on the cycle with o_last=1.
3. Stall: load 4'b1011, drop i_shift_en for 3 cycles after the 2nd bit.
   -> o_sd holds 0 with o_sd_valid=1 during the stall.
   -> Stream resumes 1,1; total 7 valid cycles.
4. Busy input: load 4'b1011, then drive i_d=4'b0000 with i_valid=1 during bits 1-2.
   -> o_ready=0; output stays 1,0,1,1.
   -> 4'b0000 is accepted only on the last-bit edge.
5. Reset mid-word: assert i_rst low between edges during the 2nd bit.
   -> o_sd_valid, o_sd and o_last go 0 immediately, without a clock edge.
   -> After release, IDLE with o_ready=1.
6. LSB_FIRST=1, DATA_WIDTH=8: load 8'hA5.
   -> o_sd = 1,0,1,0,0,1,0,1; o_last on the 8th bit.
